// File: rtl/clk_enable_bank.sv
// Multi-channel clock-enable generator. Holds sys_rst until the synchronised PLL lock
// has been stable for LOCK_CYCLES cycles, then emits per-channel tick pulses and phase
// toggles at runtime-programmable divide ratios (period = div + 1 cycles).
module clk_enable_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 26,
  parameter int unsigned LOCK_CYCLES = 1024,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_lock,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] phase,
  output logic                sys_rst,
  output logic                locked
);

  localparam int unsigned StabW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [StabW-1:0] StabLast = StabW'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DivReset = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {StWaitLock, StStable, StRun} state_e;

  logic             lock_meta, lock_s;
  state_e           state_q, state_d;
  logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
  logic             run_next;

  logic [CHANNELS-1:0][DIV_W-1:0] div_pend_q, div_pend_d;
  logic [CHANNELS-1:0][DIV_W-1:0] div_act_q, div_act_d;
  logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]            tick_d, phase_d;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Lock-stability FSM next state.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s) begin
          state_d    = StStable;
          stab_cnt_d = '0;
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (stab_cnt_q == StabLast) begin
          state_d = StRun;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Channels follow the next state so they start and stop on the sys_rst edge.
  assign run_next = (state_d == StRun);

  // FSM state and registered reset/lock outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWaitLock;
      stab_cnt_q <= '0;
      sys_rst    <= 1'b1;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      sys_rst    <= ~run_next;
      locked     <= run_next;
    end
  end

  // Per-channel divider next state, including config capture and reload.
  always_comb begin
    div_pend_d = div_pend_q;
    div_act_d  = div_act_q;
    cnt_d      = cnt_q;
    tick_d     = '0;
    phase_d    = phase;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      logic             hit;
      logic [DIV_W-1:0] new_div;
      hit     = cfg_we && (cfg_ch == CH_W'(i));
      // A same-cycle write bypasses div_pend so it applies to the period starting now.
      new_div = hit ? cfg_div : div_pend_q[i];
      div_pend_d[i] = new_div;
      if (!run_next) begin
        phase_d[i] = 1'b0;
      end
      if (!(run_next && ch_en[i])) begin
        // Idle: discard any partial count and track the pending ratio.
        div_act_d[i] = new_div;
        cnt_d[i]     = new_div;
      end else if (cnt_q[i] == '0) begin
        tick_d[i]    = 1'b1;
        phase_d[i]   = ~phase[i];
        div_act_d[i] = new_div;
        cnt_d[i]     = new_div;
      end else begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Per-channel divider registers and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_pend_q <= {CHANNELS{DivReset}};
      div_act_q  <= {CHANNELS{DivReset}};
      cnt_q      <= {CHANNELS{DivReset}};
      tick       <= '0;
      phase      <= '0;
    end else begin
      div_pend_q <= div_pend_d;
      div_act_q  <= div_act_d;
      cnt_q      <= cnt_d;
      tick       <= tick_d;
      phase      <= phase_d;
    end
  end

endmodule
